frq_div_prog: RTL and testbench
===============================

FRQ_DIV_PROG -- requirements
Module: frq_div_prog

Interface
REQ-001 Parameter WIDTH, default 16: width of divisor and counter; divisors 0..2^WIDTH-1.
REQ-002 Parameter DIV_INIT, default 100: active divisor after reset; SHALL be < 2^WIDTH.
REQ-003 iClk_in  in  1  single clock, rising-edge; all state SHALL be clocked by it.
REQ-004 iRst  in  1  reset, asynchronous, active-low.
REQ-005 iEn  in  1  count enable; low SHALL freeze the counter and oDivClk.
REQ-006 iDiv  in  WIDTH  new divisor value, sampled only when iLoad=1.
REQ-007 iLoad  in  1  one-cycle strobe capturing iDiv into the shadow register.
REQ-008 iSync  in  1  synchronous phase restart strobe.
REQ-009 oClk_out  out  1  combinational pass-through of iClk_in.
REQ-010 oDivClk  out  1  registered divided clock, period N input cycles.
REQ-011 oTick  out  1  registered one-cycle pulse, once per divided period.
REQ-012 oCnt  out  WIDTH  current counter value, registered.

Function
REQ-013 State: cnt (WIDTH), nAct (active divisor), nShd (shadow divisor), pend (load pending flag).
REQ-014 With nAct>=2 and iEn=1, each edge: cnt_next = 0 if cnt==nAct-1 (wrap edge), else cnt+1.
REQ-015 oDivClk SHALL be registered as 1 iff cnt_next >= nAct - floor(nAct/2): low ceil(N/2) cycles, then high floor(N/2) cycles.
REQ-016 For N=100 after reset: oDivClk rises on the 50th enabled edge and falls on the 100th, matching the legacy fixed /100 divider.
REQ-017 oTick SHALL be 1 for exactly the one cycle following each wrap edge; 0 otherwise.
REQ-018 iLoad=1: nShd <= iDiv, pend <= 1; a later iLoad before application overwrites nShd (last wins).
REQ-019 Pending divisor SHALL be applied (nAct <= nShd, pend <= 0) only at a wrap edge, at an iSync edge, or on the next edge if nAct<2; never mid-period.
REQ-020 iLoad on the same edge as a wrap/iSync SHALL bypass: the iDiv on that edge becomes nAct immediately.
REQ-021 iEn=0: cnt, oDivClk, nAct hold; oTick forced 0; iLoad still captured into nShd.
REQ-022 iSync=1 (priority over iEn and wrap): cnt <= 0, oDivClk <= 0, oTick <= 0, pending divisor applied.
REQ-023 nAct==1: cnt held 0, oDivClk 0, oTick 1 on every enabled cycle.
REQ-024 nAct==0: divider disabled; cnt 0, oDivClk 0, oTick 0 until a nonzero divisor is applied.
REQ-025 When a new nAct is applied, counting SHALL restart at cnt=0 with oDivClk low; no short or merged period.
REQ-026 Arithmetic SHALL be unsigned WIDTH-bit; nAct-1 and floor(nAct/2) computed without overflow; cnt never exceeds nAct-1.
REQ-027 oCnt SHALL equal cnt at all times.

Reset
REQ-028 iRst=0 SHALL immediately, without a clock edge, set cnt=0, nAct=DIV_INIT, nShd=DIV_INIT, pend=0, oDivClk=0, oTick=0.
REQ-029 Reset mid-period SHALL discard any pending load; first edge after release with iEn=1 gives cnt=1.
REQ-030 oClk_out SHALL follow iClk_in during reset.

Verification
REQ-031 Reset release, iEn=1, no load -> oDivClk rises at edge 50, falls at edge 100, oTick high in cycle after edge 100; period 100 repeated 3x.
REQ-032 Load iDiv=5 during period, let it apply -> each period: oDivClk low 3, high 2; oTick every 5 cycles; oCnt 0..4.
REQ-033 nAct=100, iLoad iDiv=10 at cnt=20 -> current period completes at 100 cycles, following periods exactly 10; no glitch at switch.
REQ-034 iEn low 7 cycles at cnt=30 -> oCnt frozen at 30, oTick 0, period length 107; iSync at cnt=60 -> next cycle oCnt=0, oDivClk=0.
REQ-035 Load 1 -> oTick constant 1, oDivClk 0; load 0 -> oTick, oDivClk, oCnt all 0; load 4 -> normal /4 resumes next edge.
REQ-036 Assert iRst during oDivClk high mid-period with pending load -> outputs 0 before next edge; after release divisor is 100, not the pending value.

Source files
------------

// File: rtl/frq_div_prog.sv
// Programmable clock divider with shadowed divisor, phase sync and tick.
// Divisor changes take effect only at period boundaries or on sync.
module frq_div_prog #(
    parameter int WIDTH    = 16,
    parameter int DIV_INIT = 100
) (
    input  logic             iClk_in,
    input  logic             iRst,
    input  logic             iEn,
    input  logic [WIDTH-1:0] iDiv,
    input  logic             iLoad,
    input  logic             iSync,
    output logic             oClk_out,
    output logic             oDivClk,
    output logic             oTick,
    output logic [WIDTH-1:0] oCnt
);

    localparam logic [WIDTH-1:0] LP_INIT = WIDTH'(DIV_INIT);

    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] r_nact;
    logic [WIDTH-1:0] r_nshd;
    logic             r_pend;
    logic             r_divclk;
    logic             r_tick;

    logic [WIDTH-1:0] w_nact_m1;
    logic [WIDTH-1:0] w_thresh;
    logic             w_wrap;
    logic [WIDTH-1:0] w_cnt_next;
    logic [WIDTH-1:0] w_new_div;
    logic             w_apply;
    logic             w_nact_zero;

    // nAct-1 is only meaningful when nAct>=1, which w_wrap guards.
    assign w_nact_zero = (r_nact == '0);
    assign w_nact_m1   = r_nact - 1'b1;
    // ceil(N/2): cycles spent low before oDivClk goes high.
    assign w_thresh    = r_nact - (r_nact >> 1);
    assign w_wrap      = !w_nact_zero && (r_cnt == w_nact_m1);
    // cnt < nAct-1 when not wrapping, so the increment cannot overflow.
    assign w_cnt_next  = w_wrap ? '0 : r_cnt + 1'b1;
    // A strobe on the applying edge bypasses the shadow register.
    assign w_new_div   = iLoad ? iDiv : r_nshd;
    assign w_apply     = iLoad | r_pend;

    assign oClk_out = iClk_in;
    assign oDivClk  = r_divclk;
    assign oTick    = r_tick;
    assign oCnt     = r_cnt;

    // Counter, divisor shadowing and registered outputs.
    always_ff @(posedge iClk_in or negedge iRst) begin
        if (!iRst) begin
            r_cnt    <= '0;
            r_nact   <= LP_INIT;
            r_nshd   <= LP_INIT;
            r_pend   <= 1'b0;
            r_divclk <= 1'b0;
            r_tick   <= 1'b0;
        end else if (iSync) begin
            r_cnt    <= '0;
            r_divclk <= 1'b0;
            r_tick   <= 1'b0;
            r_pend   <= 1'b0;
            if (w_apply) begin
                r_nact <= w_new_div;
                r_nshd <= w_new_div;
            end
        end else if (!iEn) begin
            r_tick <= 1'b0;
            if (iLoad) begin
                r_nshd <= iDiv;
                r_pend <= 1'b1;
            end
        end else if (w_nact_zero) begin
            r_cnt    <= '0;
            r_divclk <= 1'b0;
            r_tick   <= 1'b0;
            r_pend   <= iLoad;
            if (r_pend) begin
                r_nact <= r_nshd;
            end
            if (iLoad) begin
                r_nshd <= iDiv;
            end
        end else begin
            r_cnt    <= w_cnt_next;
            r_tick   <= w_wrap;
            r_divclk <= (w_cnt_next >= w_thresh);
            if (w_wrap) begin
                r_pend <= 1'b0;
                if (w_apply) begin
                    r_nact <= w_new_div;
                    r_nshd <= w_new_div;
                end
            end else if (iLoad) begin
                r_nshd <= iDiv;
                r_pend <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_frq_div_prog.sv
// Self-checking bench for frq_div_prog: period-level model plus
// directed scenarios and randomized stimulus.
module tb_frq_div_prog;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        ld = 1'b0;
    logic        sy = 1'b0;
    logic [15:0] dv = '0;
    logic        oClk_out;
    logic        oDivClk;
    logic        oTick;
    logic [15:0] oCnt;

    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    frq_div_prog #(.WIDTH(16), .DIV_INIT(100)) dut (
        .iClk_in (clk),
        .iRst    (rst_n),
        .iEn     (en),
        .iDiv    (dv),
        .iLoad   (ld),
        .iSync   (sy),
        .oClk_out(oClk_out),
        .oDivClk (oDivClk),
        .oTick   (oTick),
        .oCnt    (oCnt)
    );

    // Reference: N = active divisor, el = cycles elapsed in the period.
    int m_n, m_shd, m_el;
    bit m_pend, m_div, m_tick;

    always @(posedge clk or negedge rst_n) begin : mdl
        int n, shd, el;
        bit p, t, d;
        if (!rst_n) begin
            m_n <= 100; m_shd <= 100; m_pend <= 0;
            m_el <= 0; m_div <= 0; m_tick <= 0;
        end else begin
            n = m_n; shd = m_shd; p = m_pend; el = m_el; t = 0;
            if (sy) begin
                el = 0;
                if (ld) begin n = dv; shd = dv; end
                else if (p) n = shd;
                p = 0;
            end else if (!en) begin
                if (ld) begin shd = dv; p = 1; end
            end else if (n == 0) begin
                el = 0;
                if (p) n = shd;
                p = ld;
                if (ld) shd = dv;
            end else if (el + 1 == n) begin
                el = 0; t = 1;
                if (ld) begin n = dv; shd = dv; end
                else if (p) n = shd;
                p = 0;
            end else begin
                el = el + 1;
                if (ld) begin shd = dv; p = 1; end
            end
            if (sy) d = 0;
            else if (!en) d = m_div;
            else d = (n > 0) && (el >= (n + 1) / 2);
            m_n <= n; m_shd <= shd; m_pend <= p;
            m_el <= el; m_tick <= t; m_div <= d;
        end
    end

    task automatic chk(string nm, longint act, longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    // One clock edge with the given inputs, then compare against model.
    task automatic step(bit e, bit l, logic [15:0] d, bit s);
        en = e; ld = l; dv = d; sy = s;
        @(posedge clk);
        #1;
        chk("m_cnt", oCnt, m_el);
        chk("m_divclk", oDivClk, m_div);
        chk("m_tick", oTick, m_tick);
        chk("clk_out_hi", oClk_out, 1);
    endtask

    task automatic run_until_tick(output int n);
        n = 0;
        do begin
            step(1, 0, 0, 0);
            n++;
        end while (!oTick && n < 300);
    endtask

    initial begin : stim
        int n, ticks, highs, mx;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_cnt", oCnt, 0);
        chk("rst_divclk", oDivClk, 0);
        chk("rst_tick", oTick, 0);
        chk("rst_clkout", oClk_out, 1);
        rst_n = 1'b1;

        // Default /100 from reset, three periods.
        ticks = 0; highs = 0;
        for (int k = 1; k <= 300; k++) begin
            step(1, 0, 0, 0);
            if (k == 1) chk("first_cnt", oCnt, 1);
            if (k == 49) chk("e49_low", oDivClk, 0);
            if (k == 50) chk("e50_rise", oDivClk, 1);
            if (k == 99) chk("e99_high", oDivClk, 1);
            if (k == 100) chk("e100_fall", oDivClk, 0);
            if (k == 100) chk("e100_tick", oTick, 1);
            if (k == 101) chk("e101_tick", oTick, 0);
            ticks += oTick;
            highs += oDivClk;
        end
        chk("p100_ticks", ticks, 3);
        chk("p100_highs", highs, 150);

        // Load 5 mid-period; applies at the wrap.
        step(1, 1, 5, 0);
        run_until_tick(n);
        chk("ld5_first", n, 99);
        ticks = 0; highs = 0; mx = 0;
        for (int k = 0; k < 20; k++) begin
            step(1, 0, 0, 0);
            ticks += oTick;
            highs += oDivClk;
            if (oCnt > mx) mx = oCnt;
        end
        chk("ld5_ticks", ticks, 4);
        chk("ld5_highs", highs, 8);
        chk("ld5_maxcnt", mx, 4);

        // Load 10 at cnt=20 of a /100 period.
        step(1, 1, 100, 1);
        for (int k = 0; k < 20; k++) step(1, 0, 0, 0);
        chk("c20", oCnt, 20);
        step(1, 1, 10, 0);
        run_until_tick(n);
        chk("ld10_finish", n, 79);
        run_until_tick(n);
        chk("ld10_period", n, 10);
        run_until_tick(n);
        chk("ld10_period2", n, 10);

        // Enable gap of 7 at cnt=30, then sync at cnt=60.
        step(1, 1, 100, 1);
        for (int k = 0; k < 30; k++) step(1, 0, 0, 0);
        chk("c30", oCnt, 30);
        for (int k = 0; k < 7; k++) begin
            step(0, 0, 0, 0);
            chk("frz_cnt", oCnt, 30);
            chk("frz_tick", oTick, 0);
        end
        run_until_tick(n);
        chk("p107", 37 + n, 107);
        for (int k = 0; k < 60; k++) step(1, 0, 0, 0);
        chk("c60_high", oDivClk, 1);
        step(1, 0, 0, 1);
        chk("sync_cnt", oCnt, 0);
        chk("sync_divclk", oDivClk, 0);

        // Divisor 1, then 0, then 4.
        step(1, 1, 1, 1);
        ticks = 0; highs = 0;
        for (int k = 0; k < 10; k++) begin
            step(1, 0, 0, 0);
            ticks += oTick;
            highs += oDivClk;
        end
        chk("n1_ticks", ticks, 10);
        chk("n1_highs", highs, 0);
        step(1, 1, 0, 0);
        for (int k = 0; k < 3; k++) step(1, 0, 0, 0);
        chk("n0_tick", oTick, 0);
        chk("n0_cnt", oCnt, 0);
        step(1, 1, 4, 0);
        step(1, 0, 0, 0);
        ticks = 0;
        for (int k = 0; k < 8; k++) begin
            step(1, 0, 0, 0);
            if (k == 0) chk("n4_cnt1", oCnt, 1);
            if (k == 2) chk("n4_high", oDivClk, 1);
            ticks += oTick;
        end
        chk("n4_ticks", ticks, 2);

        // Async reset while high with a pending load.
        step(1, 1, 100, 1);
        for (int k = 0; k < 60; k++) step(1, 0, 0, 0);
        chk("pre_rst_high", oDivClk, 1);
        step(1, 1, 7, 0);
        en = 0; ld = 0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_divclk", oDivClk, 0);
        chk("arst_cnt", oCnt, 0);
        chk("arst_tick", oTick, 0);
        @(posedge clk);
        #1;
        chk("arst_clkout", oClk_out, 1);
        chk("arst_hold", oCnt, 0);
        rst_n = 1'b1;
        step(1, 0, 0, 0);
        chk("rel_cnt1", oCnt, 1);
        run_until_tick(n);
        chk("rel_n100", n, 99);

        // Randomized traffic.
        for (int k = 0; k < 2000; k++) begin
            step($urandom_range(0, 7) != 0,
                 $urandom_range(0, 7) == 0,
                 16'($urandom_range(0, 12)),
                 $urandom_range(0, 39) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
